// File: rtl/rgb_pkg.sv
// Shared definitions for the RGBW word-to-serial stage: FIFO word layout,
// default line timing and the serializer FSM states.
package rgb_pkg;
  localparam int VALID_BIT        = 31;
  localparam int STREAM_RESET_BIT = 30;
  localparam int G_LSB            = 16;
  localparam int R_LSB            = 8;
  localparam int B_LSB            = 0;
  localparam int COMP_W           = 8;

  localparam int T0H_CLKS_DEF    = 29;
  localparam int T1H_CLKS_DEF    = 58;
  localparam int TBIT_CLKS_DEF   = 120;
  localparam int TRESET_CLKS_DEF = 7680;
  localparam int CNT_W           = 13;

  typedef enum logic [2:0] {
    ST_RESET_LOW,
    ST_IDLE,
    ST_DECODE,
    ST_BIT_HIGH,
    ST_BIT_LOW
  } state_t;

  typedef struct packed {
    logic              valid;
    logic              stream_reset;
    logic [COMP_W-1:0] g;
    logic [COMP_W-1:0] r;
    logic [COMP_W-1:0] b;
  } pix_t;
endpackage

// File: rtl/rgbw_wrd2sout_if.sv
// FIFO-side and line-side signals of the word-to-serial stage.
interface rgbw_wrd2sout_if;
  logic        in_fifo_empty;
  logic [31:0] in_word;
  logic        out_rd_strobe;
  logic        out_serial;
  logic        out_busy;

  modport slave  (input  in_fifo_empty, in_word,
                  output out_rd_strobe, out_serial, out_busy);
  modport master (output in_fifo_empty, in_word,
                  input  out_rd_strobe, out_serial, out_busy);
endinterface

// File: rtl/rgbw_min_sub.sv
// RGB to RGBW split: W is the common minimum, removed from every component.
module rgbw_min_sub import rgb_pkg::*; #(
  parameter int W = COMP_W
) (
  input  logic [W-1:0] g,
  input  logic [W-1:0] r,
  input  logic [W-1:0] b,
  output logic [W-1:0] g_o,
  output logic [W-1:0] r_o,
  output logic [W-1:0] b_o,
  output logic [W-1:0] w_o
);
  logic [W-1:0] gr_min;

  // W never exceeds any component, so the subtractions cannot wrap.
  always_comb begin
    gr_min = (g < r) ? g : r;
    w_o    = (gr_min < b) ? gr_min : b;
    g_o    = g - w_o;
    r_o    = r - w_o;
    b_o    = b - w_o;
  end
endmodule

// File: rtl/rgbw_wrd2sout.sv
// Pops G/R/B words from a FWFT FIFO and drives them as G-R-B-W, MSB first,
// on an SK6812-RGBW style line; stream-reset words become a long low period.
module rgbw_wrd2sout import rgb_pkg::*; #(
  parameter int T0H_CLKS    = T0H_CLKS_DEF,
  parameter int T1H_CLKS    = T1H_CLKS_DEF,
  parameter int TBIT_CLKS   = TBIT_CLKS_DEF,
  parameter int TRESET_CLKS = TRESET_CLKS_DEF
) (
  input logic             clk,
  input logic             rst,
  rgbw_wrd2sout_if.slave  bus
);
  localparam logic [CNT_W-1:0] T0H_LAST  = CNT_W'(T0H_CLKS - 1);
  localparam logic [CNT_W-1:0] T1H_LAST  = CNT_W'(T1H_CLKS - 1);
  localparam logic [CNT_W-1:0] TBIT_LAST = CNT_W'(TBIT_CLKS - 1);
  localparam logic [CNT_W-1:0] TRST_LAST = CNT_W'(TRESET_CLKS - 1);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  pix_t              pix_q;
  logic [31:0]       shreg;
  logic [4:0]        bit_idx;
  logic              serial_q;
  logic              busy_q;
  logic [COMP_W-1:0] g_adj, r_adj, b_adj, w_val;
  logic              unused_rsvd;

  assign unused_rsvd = ^bus.in_word[29:24];

  rgbw_min_sub #(.W(COMP_W)) u_min (
    .g   (pix_q.g),
    .r   (pix_q.r),
    .b   (pix_q.b),
    .g_o (g_adj),
    .r_o (r_adj),
    .b_o (b_adj),
    .w_o (w_val)
  );

  // The pop must coincide with the latch in IDLE, so it stays combinational.
  assign bus.out_rd_strobe = (state == ST_IDLE) && !bus.in_fifo_empty;
  assign bus.out_serial    = serial_q;
  assign bus.out_busy      = busy_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_RESET_LOW;
      cnt      <= '0;
      pix_q    <= '0;
      shreg    <= '0;
      bit_idx  <= '0;
      serial_q <= 1'b0;
      busy_q   <= 1'b1;
    end else begin
      case (state)
        ST_RESET_LOW: begin
          if (cnt == TRST_LAST) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            busy_q <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_IDLE: begin
          if (!bus.in_fifo_empty) begin
            pix_q.valid        <= bus.in_word[VALID_BIT];
            pix_q.stream_reset <= bus.in_word[STREAM_RESET_BIT];
            pix_q.g            <= bus.in_word[G_LSB +: COMP_W];
            pix_q.r            <= bus.in_word[R_LSB +: COMP_W];
            pix_q.b            <= bus.in_word[B_LSB +: COMP_W];
            state              <= ST_DECODE;
            busy_q             <= 1'b1;
          end
        end
        ST_DECODE: begin
          cnt <= '0;
          if (!pix_q.valid) begin
            state  <= ST_IDLE;
            busy_q <= 1'b0;
          end else if (pix_q.stream_reset) begin
            state <= ST_RESET_LOW;
          end else begin
            shreg    <= {g_adj, r_adj, b_adj, w_val};
            bit_idx  <= 5'd31;
            state    <= ST_BIT_HIGH;
            serial_q <= 1'b1;
          end
        end
        ST_BIT_HIGH: begin
          // Counter keeps running into BIT_LOW so the bit period stays fixed.
          cnt <= cnt + 1'b1;
          if (cnt == (shreg[31] ? T1H_LAST : T0H_LAST)) begin
            state    <= ST_BIT_LOW;
            serial_q <= 1'b0;
          end
        end
        ST_BIT_LOW: begin
          if (cnt == TBIT_LAST) begin
            cnt   <= '0;
            shreg <= {shreg[30:0], 1'b0};
            if (bit_idx == 5'd0) begin
              state  <= ST_IDLE;
              busy_q <= 1'b0;
            end else begin
              bit_idx  <= bit_idx - 1'b1;
              state    <= ST_BIT_HIGH;
              serial_q <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state    <= ST_RESET_LOW;
          cnt      <= '0;
          serial_q <= 1'b0;
          busy_q   <= 1'b1;
        end
      endcase
    end
  end
endmodule
